crc33_d264_checker: RTL

- Receive-side checker for the 264-bit-payload CRC-33 frame format. The generator is polynomial p(0 to 33) = all ones, i.e. G(x) = x^33 + x^32 + … + x + 1. The first serial bit is D[263].
- Accepts a frame as BEATS data beats plus one CRC beat over a valid/ready stream.
- Recomputes the CRC sequentially beat by beat and reports a one-cycle pass/fail result per frame.
- Sits at the sink end of any link carrying frames built by the matching combinational next-CRC generator.

---
 rtl/crc33_d264_checker.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/crc33_d264_checker.sv
// ---------------------------------------------------------------------------
// crc33_d264_checker
//
// Receive-side CRC-33 checker for frames carrying a 264-bit payload.
// Generator G(x) = x^33 + x^32 + ... + x + 1 (all 34 coefficients set).
// The first serial bit is D[263]. Bit DW-1 of every beat is processed first.
//
// A frame is BEATS data beats (the first one flagged by in_sof) followed by
// one CRC beat whose bits [32:0] hold the transmitted CRC. The CRC is folded
// one whole beat per cycle, and a one-cycle result strobe reports pass/fail.
// An in_sof arriving in the middle of a frame aborts it; that sof beat then
// starts the next frame.
//
// Optional feature macro: CRC33_CHK_ERR_CNT_EN
//   defined     -> err_cnt counts failed results (aborts included) and
//                  saturates at 16'hFFFF; cleared only by reset.
//   not defined -> err_cnt is tied to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   beat valid
//   in_ready   checker can accept a beat (low during reset and report cycle)
//   in_sof     first data beat of a frame
//   in_data    beat payload (CRC beat uses [32:0] only)
//   res_valid  one-cycle result strobe
//   res_ok     received CRC matched (qualified by res_valid, held afterwards)
//   res_abort  frame aborted by an early in_sof (qualified by res_valid)
//   crc_calc   computed CRC of the last completed frame
//   err_cnt    failed-result counter (see macro above)
// ---------------------------------------------------------------------------
module crc33_d264_checker #(
  parameter int          DW    = 33,
  parameter int          BEATS = 8,
  parameter logic [32:0] INIT  = 33'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          res_valid,
  output logic          res_ok,
  output logic          res_abort,
  output logic [32:0]   crc_calc,
  output logic [15:0]   err_cnt
);

  localparam int          CW   = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS);
  localparam logic [32:0] POLY = {33{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_REPORT
  } state_t;

  // Fold one DW-bit beat into the CRC, MSB first, using the serial rule.
  function automatic logic [32:0] crc_beat(input logic [32:0] crc_in,
                                           input logic [DW-1:0] d);
    logic [32:0] c;
    logic        fb;
    c = crc_in;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[32] ^ d[i];
      c  = {c[31:0], 1'b0} ^ ({33{fb}} & POLY);
    end
    return c;
  endfunction

  state_t        state, state_n;
  logic [32:0]   crc_reg, crc_n;
  logic [CW-1:0] beat_cnt, cnt_n;
  logic          ready_n;
  logic          valid_n;
  logic          ok_n;
  logic          abort_n;
  logic [32:0]   calc_n;
  logic          xfer;
  logic [32:0]   crc_from_init;
  logic [32:0]   crc_from_reg;
  state_t        first_state;

  assign xfer          = in_valid && in_ready;
  assign crc_from_init = crc_beat(INIT, in_data);
  assign crc_from_reg  = crc_beat(crc_reg, in_data);
  // With a single data beat the sof beat completes the payload on its own.
  assign first_state   = (BEATS == 1) ? S_CRC : S_DATA;

  always_comb begin
    state_n = state;
    crc_n   = crc_reg;
    cnt_n   = beat_cnt;
    valid_n = 1'b0;
    ok_n    = res_ok;
    abort_n = res_abort;
    calc_n  = crc_calc;

    case (state)
      S_IDLE: begin
        // Beats without sof are silently dropped here.
        if (xfer && in_sof) begin
          crc_n   = crc_from_init;
          cnt_n   = CW'(1);
          state_n = first_state;
        end
      end

      S_DATA: begin
        if (xfer) begin
          if (in_sof) begin
            valid_n = 1'b1;
            ok_n    = 1'b0;
            abort_n = 1'b1;
            crc_n   = crc_from_init;
            cnt_n   = CW'(1);
            state_n = first_state;
          end else begin
            crc_n = crc_from_reg;
            cnt_n = beat_cnt + CW'(1);
            if (beat_cnt + CW'(1) == LAST) begin
              state_n = S_CRC;
            end
          end
        end
      end

      S_CRC: begin
        if (xfer) begin
          if (in_sof) begin
            // An sof here is payload of a new frame, not a CRC.
            valid_n = 1'b1;
            ok_n    = 1'b0;
            abort_n = 1'b1;
            crc_n   = crc_from_init;
            cnt_n   = CW'(1);
            state_n = first_state;
          end else begin
            valid_n = 1'b1;
            ok_n    = (in_data[32:0] == crc_reg);
            abort_n = 1'b0;
            calc_n  = crc_reg;
            state_n = S_REPORT;
          end
        end
      end

      S_REPORT: begin
        crc_n   = INIT;
        cnt_n   = '0;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        crc_n   = INIT;
        cnt_n   = '0;
      end
    endcase

    // Registered ready: low only in the report cycle.
    ready_n = (state_n != S_REPORT);
  end

  // ---- registered state and result stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      crc_reg   <= INIT;
      beat_cnt  <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
      res_abort <= 1'b0;
      crc_calc  <= '0;
    end else begin
      state     <= state_n;
      crc_reg   <= crc_n;
      beat_cnt  <= cnt_n;
      in_ready  <= ready_n;
      res_valid <= valid_n;
      res_ok    <= ok_n;
      res_abort <= abort_n;
      crc_calc  <= calc_n;
    end
  end

`ifdef CRC33_CHK_ERR_CNT_EN
  // Updated together with the result so the count is current at res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (valid_n && !ok_n && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule
